// File: rtl/relational_obs_checker.sv
// Relational observation checker: per-copy skew FIFOs feeding an
// all-equal or 4-way implication compare across self-composed copies.
module relational_obs_checker #(
    parameter int NCOPY = 4,
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 16,
    parameter int MODE  = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [NCOPY-1:0]   obs_valid,
    input  logic [NCOPY*W-1:0] obs_data,
    output logic [1:0]         state,
    output logic               violation,
    output logic               overflow,
    output logic               vacuous,
    output logic [CW-1:0]      match_count,
    output logic               busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FAIL = 2'b10
    } state_t;

    state_t stateQ;

    logic [W-1:0]  mem   [NCOPY][DEPTH];
    logic [AW-1:0] rdPtr [NCOPY];
    logic [AW-1:0] wrPtr [NCOPY];
    logic [OW-1:0] occ   [NCOPY];
    logic [W-1:0]  heads [NCOPY];

    logic [NCOPY-1:0] nonEmpty;
    logic [NCOPY-1:0] pushOk;
    logic [NCOPY-1:0] pushDrop;
    logic running;
    logic doCompare;
    logic srcEq;
    logic trgEq;
    logic cmpPass;
    logic cmpFail;
    logic cmpVac;
    logic anyDrop;

    always_comb begin
        running = (stateQ == RUN);
        for (int i = 0; i < NCOPY; i++) begin
            heads[i]    = mem[i][rdPtr[i]];
            nonEmpty[i] = (occ[i] != '0);
        end
        doCompare = running && (&nonEmpty);
        for (int i = 0; i < NCOPY; i++) begin
            // A full FIFO may still accept a word when its head pops this cycle
            pushOk[i]   = !reset && running && obs_valid[i]
                          && ((occ[i] != FULL) || doCompare);
            pushDrop[i] = running && obs_valid[i]
                          && (occ[i] == FULL) && !doCompare;
        end
        anyDrop = |pushDrop;
    end

    generate
        if (MODE == 1 && NCOPY == 4) begin : gImpl
            assign srcEq = (heads[0] == heads[1]);
            assign trgEq = (heads[2] == heads[3]);
        end else begin : gAllEq
            logic allEq;
            always_comb begin
                allEq = 1'b1;
                for (int i = 1; i < NCOPY; i++)
                    if (heads[i] != heads[0]) allEq = 1'b0;
            end
            assign srcEq = 1'b1;
            assign trgEq = allEq;
        end
    endgenerate

    assign cmpPass = doCompare && srcEq && trgEq;
    assign cmpFail = doCompare && srcEq && !trgEq;
    assign cmpVac  = doCompare && !srcEq;

    always_ff @(posedge clock) begin
        for (int i = 0; i < NCOPY; i++)
            if (pushOk[i]) mem[i][wrPtr[i]] <= obs_data[i*W +: W];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ      <= IDLE;
            violation   <= 1'b0;
            overflow    <= 1'b0;
            vacuous     <= 1'b0;
            match_count <= '0;
            for (int i = 0; i < NCOPY; i++) begin
                rdPtr[i] <= '0;
                wrPtr[i] <= '0;
                occ[i]   <= '0;
            end
        end else begin
            unique case (stateQ)
                IDLE: if (start) stateQ <= RUN;
                RUN: begin
                    for (int i = 0; i < NCOPY; i++) begin
                        if (pushOk[i]) wrPtr[i] <= wrPtr[i] + AW'(1);
                        if (doCompare) rdPtr[i] <= rdPtr[i] + AW'(1);
                        occ[i] <= occ[i] + OW'(pushOk[i]) - OW'(doCompare);
                    end
                    if (cmpPass && match_count != {CW{1'b1}})
                        match_count <= match_count + CW'(1);
                    if (cmpFail) violation <= 1'b1;
                    if (cmpVac) vacuous <= 1'b1;
                    if (anyDrop) overflow <= 1'b1;
                    if (cmpFail || anyDrop) stateQ <= FAIL;
                end
                FAIL: stateQ <= FAIL;
                default: stateQ <= IDLE;
            endcase
        end
    end

    assign state = stateQ;
    assign busy  = |nonEmpty;

endmodule

// File: tb/tb_relational_obs_checker.sv
// Directed bench: 4-copy implication instance plus a 2-copy all-equal
// instance with a 2-bit saturating counter.
module tb_relational_obs_checker;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [3:0] ov;
    logic [127:0] od;
    logic [1:0] st;
    logic vio, ovf, vac, bsy;
    logic [15:0] mc;

    logic [1:0] ov2;
    logic [15:0] od2;
    logic [1:0] st2;
    logic vio2, ovf2, vac2, bsy2;
    logic [1:0] mc2;

    int nTests = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    relational_obs_checker dut (
        .clock(clk), .reset(rst), .start(start),
        .obs_valid(ov), .obs_data(od),
        .state(st), .violation(vio), .overflow(ovf), .vacuous(vac),
        .match_count(mc), .busy(bsy)
    );

    relational_obs_checker #(
        .NCOPY(2), .W(8), .DEPTH(2), .CW(2), .MODE(0)
    ) dut2 (
        .clock(clk), .reset(rst), .start(start),
        .obs_valid(ov2), .obs_data(od2),
        .state(st2), .violation(vio2), .overflow(ovf2), .vacuous(vac2),
        .match_count(mc2), .busy(bsy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        start = 1'b0;
        ov = '0;
        ov2 = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic doStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        ov = 4'hF;
        ov2 = 2'b11;
        tick();
        rst = 1'b0;
        start = 1'b0;
        ov = '0;
        ov2 = '0;
        nTests++;
        if ({st, vio, ovf, vac, bsy, mc} !== 22'd0) begin
            nFail++;
            $display("FAIL reset_dut: got st=%0h v=%0b o=%0b q=%0b b=%0b mc=%0d want all 0",
                     st, vio, ovf, vac, bsy, mc);
        end
        nTests++;
        if ({st2, vio2, ovf2, vac2, bsy2, mc2} !== 8'd0) begin
            nFail++;
            $display("FAIL reset_dut2: got st=%0h v=%0b o=%0b q=%0b b=%0b mc=%0d want all 0",
                     st2, vio2, ovf2, vac2, bsy2, mc2);
        end
    endtask

    task automatic test_all_match();
        doReset();
        doStart();
        nTests++;
        if (st !== 2'b01) begin
            nFail++; $display("FAIL start_run: got %0h want 1", st);
        end
        ov = 4'hF;
        od = {4{32'h11}};
        tick();
        ov = '0;
        nTests++;
        if (bsy !== 1'b1 || mc !== 16'd0) begin
            nFail++; $display("FAIL match_pushed: got b=%0b mc=%0d want b=1 mc=0", bsy, mc);
        end
        tick();
        nTests++;
        if (mc !== 16'd1 || vio !== 1'b0 || bsy !== 1'b0 || st !== 2'b01) begin
            nFail++;
            $display("FAIL match_compare: got mc=%0d v=%0b b=%0b st=%0h want 1 0 0 1",
                     mc, vio, bsy, st);
        end
    endtask

    task automatic test_violation();
        doReset();
        doStart();
        ov = 4'hF;
        od = {32'h02, 32'h01, 32'hA5, 32'hA5};
        tick();
        ov = '0;
        tick();
        nTests++;
        if (vio !== 1'b1 || st !== 2'b10 || mc !== 16'd0 || vac !== 1'b0) begin
            nFail++;
            $display("FAIL violation: got v=%0b st=%0h mc=%0d q=%0b want 1 2 0 0",
                     vio, st, mc, vac);
        end
        ov = 4'hF;
        od = {4{32'h33}};
        tick();
        tick();
        ov = '0;
        tick();
        nTests++;
        if (st !== 2'b10 || bsy !== 1'b0 || mc !== 16'd0 || ovf !== 1'b0) begin
            nFail++;
            $display("FAIL fail_frozen: got st=%0h b=%0b mc=%0d o=%0b want 2 0 0 0",
                     st, bsy, mc, ovf);
        end
    endtask

    task automatic test_vacuous();
        doReset();
        doStart();
        ov = 4'hF;
        od = {4{32'h7}};
        tick();
        od = {32'h04, 32'h03, 32'h20, 32'h10};
        tick();
        ov = '0;
        tick();
        nTests++;
        if (vac !== 1'b1 || vio !== 1'b0 || st !== 2'b01 || mc !== 16'd1) begin
            nFail++;
            $display("FAIL vacuous: got q=%0b v=%0b st=%0h mc=%0d want 1 0 1 1",
                     vac, vio, st, mc);
        end
    endtask

    task automatic test_overflow();
        doReset();
        doStart();
        ov = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            od = 128'(k + 1);
            tick();
        end
        nTests++;
        if (st !== 2'b01 || ovf !== 1'b0 || bsy !== 1'b1) begin
            nFail++;
            $display("FAIL full_no_ovf: got st=%0h o=%0b b=%0b want 1 0 1", st, ovf, bsy);
        end
        od = 128'd5;
        tick();
        ov = '0;
        nTests++;
        if (ovf !== 1'b1 || st !== 2'b10 || vio !== 1'b0) begin
            nFail++;
            $display("FAIL overflow: got o=%0b st=%0h v=%0b want 1 2 0", ovf, st, vio);
        end
    endtask

    task automatic test_skew();
        logic [31:0] a;
        logic [31:0] b;
        doReset();
        doStart();
        for (int c = 0; c < 8; c++) begin
            a = 32'(100 + c);
            b = 32'(97 + c);
            ov = {(c >= 3 && c < 7) ? 3'b111 : 3'b000, c < 4};
            od = {b, b, b, a};
            tick();
        end
        ov = '0;
        nTests++;
        if (mc !== 16'd4 || ovf !== 1'b0 || vio !== 1'b0 || vac !== 1'b0) begin
            nFail++;
            $display("FAIL skew_mc: got mc=%0d o=%0b v=%0b q=%0b want 4 0 0 0",
                     mc, ovf, vio, vac);
        end
        nTests++;
        if (bsy !== 1'b0 || st !== 2'b01) begin
            nFail++; $display("FAIL skew_drain: got b=%0b st=%0h want 0 1", bsy, st);
        end
    endtask

    task automatic test_saturation();
        doReset();
        doStart();
        ov2 = 2'b11;
        for (int k = 0; k < 5; k++) begin
            od2 = {8'(k + 1), 8'(k + 1)};
            tick();
        end
        ov2 = '0;
        tick();
        nTests++;
        if (mc2 !== 2'd3 || vio2 !== 1'b0 || ovf2 !== 1'b0 || bsy2 !== 1'b0) begin
            nFail++;
            $display("FAIL saturate: got mc=%0d v=%0b o=%0b b=%0b want 3 0 0 0",
                     mc2, vio2, ovf2, bsy2);
        end
        rst = 1'b1;
        ov2 = 2'b11;
        tick();
        rst = 1'b0;
        ov2 = '0;
        nTests++;
        if ({st2, vio2, ovf2, vac2, bsy2, mc2} !== 8'd0) begin
            nFail++;
            $display("FAIL sat_reset: got st=%0h mc=%0d b=%0b want all 0", st2, mc2, bsy2);
        end
    endtask

    task automatic test_mode0_mismatch();
        doReset();
        doStart();
        ov2 = 2'b11;
        od2 = {8'h02, 8'h01};
        tick();
        ov2 = '0;
        tick();
        nTests++;
        if (vio2 !== 1'b1 || st2 !== 2'b10 || mc2 !== 2'd0 || vac2 !== 1'b0) begin
            nFail++;
            $display("FAIL mode0_vio: got v=%0b st=%0h mc=%0d q=%0b want 1 2 0 0",
                     vio2, st2, mc2, vac2);
        end
    endtask

    task automatic test_start_push();
        doReset();
        start = 1'b1;
        ov2 = 2'b11;
        od2 = 16'h4242;
        tick();
        start = 1'b0;
        ov2 = '0;
        nTests++;
        if (st2 !== 2'b01 || bsy2 !== 1'b0) begin
            nFail++; $display("FAIL idle_push: got st=%0h b=%0b want 1 0", st2, bsy2);
        end
        tick();
        nTests++;
        if (bsy2 !== 1'b0 || mc2 !== 2'd0) begin
            nFail++; $display("FAIL idle_push2: got b=%0b mc=%0d want 0 0", bsy2, mc2);
        end
    endtask

    task automatic test_reset_priority();
        doReset();
        doStart();
        ov = 4'b0011;
        od = {4{32'h9}};
        tick();
        rst = 1'b1;
        start = 1'b1;
        ov = 4'hF;
        tick();
        rst = 1'b0;
        start = 1'b0;
        ov = '0;
        nTests++;
        if (st !== 2'b00 || bsy !== 1'b0 || mc !== 16'd0) begin
            nFail++;
            $display("FAIL reset_prio: got st=%0h b=%0b mc=%0d want 0 0 0", st, bsy, mc);
        end
        tick();
        nTests++;
        if (st !== 2'b00) begin
            nFail++; $display("FAIL stay_idle: got %0h want 0", st);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ov = '0;
        od = '0;
        ov2 = '0;
        od2 = '0;
        test_reset();
        test_all_match();
        test_violation();
        test_vacuous();
        test_overflow();
        test_skew();
        test_saturation();
        test_mode0_mismatch();
        test_start_push();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/relational_obs_checker.md
RELATIONAL_OBS_CHECKER -- requirements
Module: relational_obs_checker

Interface
REQ-001 Parameter NCOPY, default 4, number of self-composed copies observed (legal 2..4).
REQ-002 Parameter W, default 32, observation word width in bits.
REQ-003 Parameter DEPTH, default 4, per-copy skew FIFO depth (power of 2, >=2).
REQ-004 Parameter CW, default 16, width of match counter.
REQ-005 Parameter MODE, default 1: 0 = all-equal check; 1 = 4-way implication check (requires NCOPY=4).
REQ-006 clock  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  moves checker from IDLE to RUN.
REQ-009 obs_valid  input  NCOPY  bit i = copy i presents an observation this cycle.
REQ-010 obs_data  input  NCOPY*W  copy i observation in bits [i*W +: W].
REQ-011 state  output  2  00 IDLE, 01 RUN, 10 FAIL.
REQ-012 violation  output  1  sticky; relational property broken.
REQ-013 overflow  output  1  sticky; a push hit a full FIFO.
REQ-014 vacuous  output  1  sticky; MODE 1 only, source pair (copies 0,1) diverged.
REQ-015 match_count  output  CW  number of compare events that passed.
REQ-016 busy  output  1  any FIFO non-empty.

Function
REQ-017 Reset values: state IDLE, violation 0, overflow 0, vacuous 0, match_count 0, busy 0, all FIFOs empty.
REQ-018 IDLE -> RUN on start=1; start ignored in RUN and FAIL; obs_valid ignored in IDLE.
REQ-019 RUN -> FAIL on the same edge that sets violation or overflow; FAIL left only by reset.
REQ-020 In FAIL: no push, no pop, match_count and sticky flags frozen.
REQ-021 In RUN, obs_valid[i]=1 pushes obs_data word i into FIFO i at the edge.
REQ-022 Compare event: in RUN, all NCOPY FIFOs non-empty -> pop every head at the edge; evaluate heads combinationally that cycle.
REQ-023 Pop and push on the same FIFO in one cycle both take effect; legal when full (occupancy unchanged).
REQ-024 Push to a full FIFO without simultaneous pop: word dropped, overflow=1 next cycle, state FAIL.
REQ-025 MODE 0: pass iff every head equals head 0; otherwise violation=1 next cycle.
REQ-026 MODE 1: src_eq = (head0==head1), trg_eq = (head2==head3); violation iff src_eq && !trg_eq.
REQ-027 MODE 1: !src_eq sets vacuous=1 next cycle, does not set violation, does not increment match_count; state stays RUN.
REQ-028 match_count increments by 1 on each passing compare event (MODE 1: src_eq && trg_eq); saturates at 2^CW-1, no wrap.
REQ-029 Flag and counter latency: exactly 1 cycle after the compare edge.
REQ-030 Overflow and violation in the same cycle: both flags set, state FAIL.
REQ-031 FIFO pointers log2(DEPTH) bits with separate occupancy count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-032 busy = OR over copies of (occupancy != 0), registered view of current occupancy.
REQ-033 Copies may present observations in different cycles; ordering per copy preserved (FIFO order).

Reset
REQ-034 reset=1 at any edge, including mid-compare or in FAIL, restores all REQ-017 values on that edge; pushes/pops that cycle discarded.
REQ-035 reset has priority over start, obs_valid and compare events.

Verification
REQ-036 MODE 1, start, all four copies push 0x11 same cycle -> next cycle match_count=1, violation=0, busy=0.
REQ-037 MODE 1, copies 0,1 push 0xA5, copy 2 pushes 0x01, copy 3 pushes 0x02 -> violation=1, state=FAIL, later pushes ignored, match_count frozen.
REQ-038 MODE 1, copy 0 pushes 0x10, copy 1 pushes 0x20, copies 2,3 differ -> vacuous=1, violation=0, state RUN, match_count unchanged.
REQ-039 DEPTH=4, copy 0 pushes 5 words while others silent -> after 5th push overflow=1, state=FAIL; copies skewed by 3 words then catch up -> 4 compares pass, match_count=4.
REQ-040 CW=2, 5 passing compares -> match_count sticks at 3; reset asserted in next cycle -> all outputs at REQ-017 values, state IDLE.
REQ-041 MODE 0, NCOPY=2, start and first push same cycle -> push ignored (IDLE), busy stays 0.
